fifo_beat_packer: RTL
=====================

# fifo_beat_packer

Upstream feeder for the team's flip-flop FIFO. It gathers narrow beats from a valid/ready byte stream into one wide word and pushes that word into the FIFO. A word closes after `ratio` beats, or early on a beat flagged `in_last`; each word carries a field giving the number of lanes that hold data. The block respects FIFO `full`, so the FIFO never sees a push while it is full.

## Interface
- `in_width`, 8: width of one input beat.
- `ratio`, 4: beats per full word; must be ≥ 2.
- `cnt_width` (localparam), `$clog2(ratio+1)`: width of the valid-lane count field.
- `word_width` (localparam), `ratio*in_width + cnt_width`: width of `write_data`; the FIFO `width` parameter is set to this value.

Ports (reset `rst`, asynchronous, active-high; clock `clk`):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready` at a rising edge.
- `in_data`  in  `in_width`  beat payload.
- `in_last`  in  1  close the word after this beat.
- `full`  in  1  FIFO full flag.
- `push`  out  1  FIFO write strobe.
- `write_data`  out  `word_width`  `{count, lanes}`; lane k is bits `[k*in_width +: in_width]`.

## Operation
- State `ACCUM`: the word is being filled; `beat_cnt` runs 0..`ratio`-1.
- State `HOLD`: a complete word is waiting for the FIFO.
- Accepted beat in `ACCUM`: written to lane `beat_cnt`; `beat_cnt` increments.
- If the beat is the `ratio`-th or has `in_last=1`: latch `count = beat_cnt+1` and go to `HOLD`.
- Lanes at or above `count` are zero.
- `in_ready = (state==ACCUM) | ~full`.
- `push = (state==HOLD) & ~full`. It is combinational from registered state and `full`; no other path asserts it.
- `write_data` is driven directly from the registers and stays stable throughout `HOLD`.
- `HOLD` with `full=1`: no push, `in_ready=0`, all registers hold.
- `HOLD` with `full=0`: push this cycle and return to `ACCUM`. If `in_valid` is also high, that beat is accepted into lane 0 of a cleared word, so `beat_cnt=1` next cycle.
  - If that beat has `in_last=1` (or `ratio` would be reached), the next state is `HOLD` with `count=1`.
- `in_last` on a beat with `beat_cnt==ratio-1`: normal full word, `count=ratio`.
- A word is never pushed with `count=0`; an idle `ACCUM` never pushes.
- `in_data`/`in_last` are ignored when `in_valid=0`.
- Reset (any cycle, including mid-word or in `HOLD`): state `ACCUM`, `beat_cnt=0`, lanes and `count` zero.
  - Outputs at reset: `push=0`, `write_data=0`, `in_ready=1`.
  - A partially packed or held word is discarded.

## Timing
- Word closed by the beat accepted at edge N: `push` is high in the cycle after edge N, provided `full=0`.
- Sustained input with `full=0`: one push every `ratio` beats with no input bubbles, i.e. 100% input throughput.
- Back-pressure stalls input by exactly the number of cycles `full` stays high while in `HOLD`.
- No combinational path from `in_valid` to `push`. `full` reaches `in_ready` and `push` combinationally; this is the only input-to-output path.

## Structure
- Single module; no sub-module.
- State enum (`ACCUM`, `HOLD`) is a 1-bit typedef in the shared stream package, `stream_pkg`, used by future packer/unpacker stages.
- `cnt_width` and `word_width` are local; the top level reuses `word_width` when instantiating the FIFO.

## Test plan
- ratio=4, beats 0x11,0x22,0x33,0x44 on consecutive cycles, `full=0` -> one `push` the cycle after 0x44, `write_data={3'd4, 32'h44332211}`.
- Beats 0x11 then 0x22 with `in_last=1` -> `push` next cycle, `write_data={3'd2, 32'h00002211}`.
- Complete word, then `full=1` for 3 cycles -> `push=0`, `in_ready=0`, `write_data` unchanged for 3 cycles; `push=1` on the first cycle with `full=0`.
- Eight back-to-back beats 0x01..0x08, `full=0` -> `in_ready` high throughout; pushes of 0x04030201 and 0x08070605 four cycles apart, `count=4` each.
- In `HOLD` with `full=0`, `in_valid=1`, `in_last=1`, data 0xAA -> push of the old word that cycle, then push of `{3'd1, 32'h000000AA}` the next cycle.
- `rst` pulsed after 2 beats, then beats 0xA0..0xA3 -> single push `{3'd4, 32'hA3A2A1A0}`; no push of the partial word.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the byte-stream packer/unpacker stages.
package stream_pkg;

  // Packer state: ACCUM while a word is being filled, HOLD while a finished word waits for the FIFO.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } pack_state_e;

endpackage

// File: rtl/fifo_beat_packer.sv
// Gathers narrow valid/ready beats into one wide word {count, lanes} and
// pushes it into the flip-flop FIFO, never pushing while the FIFO is full.
//
//   state | meaning
//   ACCUM | word being filled, beat_cnt = next lane to write
//   HOLD  | word complete, waiting for FIFO space (push when ~full)
module fifo_beat_packer
  import stream_pkg::*;
#(
  parameter  int in_width   = 8,
  parameter  int ratio      = 4,
  localparam int cnt_width  = $clog2(ratio + 1),
  localparam int word_width = ratio * in_width + cnt_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [in_width-1:0]   in_data,
  input  logic                  in_last,
  input  logic                  full,
  output logic                  push,
  output logic [word_width-1:0] write_data
);

  localparam int idx_width = $clog2(ratio);
  localparam logic [idx_width-1:0] last_idx = idx_width'(ratio - 1);

  pack_state_e                         state;
  logic [idx_width-1:0]                beat_cnt;
  logic [cnt_width-1:0]                count;
  logic [ratio-1:0][in_width-1:0]      lanes;

  // Handshake and FIFO strobe depend only on registered state and full.
  assign in_ready   = (state == ACCUM) | ~full;
  assign push       = (state == HOLD) & ~full;
  assign write_data = {count, lanes};

  // Packing state machine; HOLD with space pushes and may take a new beat into a cleared word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      beat_cnt <= '0;
      count    <= '0;
      lanes    <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            lanes[beat_cnt] <= in_data;
            if (in_last || (beat_cnt == last_idx)) begin
              count    <= cnt_width'(beat_cnt) + cnt_width'(1);
              beat_cnt <= '0;
              state    <= HOLD;
            end else begin
              beat_cnt <= beat_cnt + idx_width'(1);
            end
          end
        end
        HOLD: begin
          if (!full) begin
            lanes    <= '0;
            count    <= '0;
            beat_cnt <= '0;
            state    <= ACCUM;
            if (in_valid) begin
              lanes[0] <= in_data;
              // ratio >= 2, so a single beat only closes the word via in_last
              if (in_last) begin
                count <= cnt_width'(1);
                state <= HOLD;
              end else begin
                beat_cnt <= idx_width'(1);
              end
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
